// File: rtl/serv_ram_responder_pkg.sv
// Shared types and helpers for the SERV RAM responder: FSM state encoding,
// grant codes and the byte-lane placement used by the host loader.
package serv_ram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_HOST = 2'd1,
        GNT_DBUS = 2'd2,
        GNT_IBUS = 2'd3
    } grant_t;

    // Place a byte on its lane within a 32-bit word.
    function automatic logic [31:0] lane_shift(input logic [7:0] data, input logic [1:0] lane);
        return {24'b0, data} << {lane, 3'b000};
    endfunction

    // One-hot byte write enable for a lane.
    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/serv_mem_arb.sv
// Fixed-priority grant (host > dbus > ibus), only offered while the FSM is idle.
module serv_mem_arb
    import serv_ram_responder_pkg::*;
(
    input  logic   i_idle,
    input  logic   i_host_req,
    input  logic   i_dbus_req,
    input  logic   i_ibus_req,
    output grant_t o_grant
);

    // Priority select, no grant outside IDLE.
    always_comb begin
        o_grant = GNT_NONE;
        if (i_idle) begin
            if (i_host_req) begin
                o_grant = GNT_HOST;
            end else if (i_dbus_req) begin
                o_grant = GNT_DBUS;
            end else if (i_ibus_req) begin
                o_grant = GNT_IBUS;
            end
        end
    end

endmodule

// File: rtl/serv_ram_responder.sv
// Bus responder sharing one single-port synchronous RAM between SERV's ibus,
// dbus and a host byte loader.
//
// state  | meaning
// IDLE   | arbitrate; latch the winning request
// ACCESS | drive the RAM from the latched request
// ACK    | one-cycle ack to the granted bus with read data
// GAP    | dead cycle so the initiator can drop cyc
module serv_ram_responder
    import serv_ram_responder_pkg::*;
#(
    parameter int          AW   = 5,
    parameter logic [31:0] BASE = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ibus_cyc,
    input  logic [31:0]   i_ibus_adr,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic          i_dbus_cyc,
    input  logic [31:0]   i_dbus_adr,
    input  logic          i_dbus_we,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    input  logic          i_host_we,
    input  logic [AW+1:0] i_host_addr,
    input  logic [7:0]    i_host_data,
    output logic          o_host_busy,
    output logic          o_ram_en,
    output logic [AW-1:0] o_ram_a,
    output logic [3:0]    o_ram_we,
    output logic [31:0]   o_ram_di,
    input  logic [31:0]   i_ram_do
);

    state_t        r_state;
    state_t        w_next;
    grant_t        r_grant;
    grant_t        w_grant;
    logic [AW-1:0] r_word;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [31:0]   r_dat;
    logic          r_in_range;
    logic          w_ibus_in_range;
    logic          w_dbus_in_range;
    logic [31:0]   w_rdt;
    logic          w_unused_adr_bits;

    // Byte offsets inside a word play no part in word accesses.
    assign w_unused_adr_bits = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

    assign w_ibus_in_range = (i_ibus_adr[31:AW+2] == BASE[31:AW+2]);
    assign w_dbus_in_range = (i_dbus_adr[31:AW+2] == BASE[31:AW+2]);

    serv_mem_arb u_arb (
        .i_idle     (r_state == ST_IDLE),
        .i_host_req (i_host_we),
        .i_dbus_req (i_dbus_cyc),
        .i_ibus_req (i_ibus_cyc),
        .o_grant    (w_grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the winning request while idle; held through the rest of the transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant    <= GNT_NONE;
            r_word     <= '0;
            r_we       <= 1'b0;
            r_sel      <= 4'b0;
            r_dat      <= 32'b0;
            r_in_range <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_grant <= w_grant;
            case (w_grant)
                GNT_HOST: begin
                    r_word     <= i_host_addr[AW+1:2];
                    r_we       <= 1'b1;
                    r_sel      <= lane_onehot(i_host_addr[1:0]);
                    r_dat      <= lane_shift(i_host_data, i_host_addr[1:0]);
                    r_in_range <= 1'b1;
                end
                GNT_DBUS: begin
                    r_word     <= i_dbus_adr[AW+1:2];
                    r_we       <= i_dbus_we;
                    r_sel      <= i_dbus_sel;
                    r_dat      <= i_dbus_dat;
                    r_in_range <= w_dbus_in_range;
                end
                GNT_IBUS: begin
                    r_word     <= i_ibus_adr[AW+1:2];
                    r_we       <= 1'b0;
                    r_sel      <= 4'b0;
                    r_dat      <= 32'b0;
                    r_in_range <= w_ibus_in_range;
                end
                default: begin
                    r_in_range <= 1'b0;
                end
            endcase
        end
    end

    // Read data is only meaningful for in-range reads; everything else returns zero.
    assign w_rdt = (!r_we && r_in_range) ? i_ram_do : 32'b0;

    // Next state and all outputs; everything idles at zero outside its own state.
    always_comb begin
        w_next      = r_state;
        o_ram_en    = 1'b0;
        o_ram_a     = '0;
        o_ram_we    = 4'b0;
        o_ram_di    = 32'b0;
        o_ibus_ack  = 1'b0;
        o_ibus_rdt  = 32'b0;
        o_dbus_ack  = 1'b0;
        o_dbus_rdt  = 32'b0;
        o_host_busy = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_grant != GNT_NONE) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_ram_en = r_in_range;
                o_ram_a  = r_word;
                o_ram_we = (r_we && r_in_range) ? r_sel : 4'b0;
                o_ram_di = r_dat;
                w_next   = (r_grant == GNT_HOST) ? ST_IDLE : ST_ACK;
            end
            ST_ACK: begin
                if (r_grant == GNT_IBUS) begin
                    o_ibus_ack = 1'b1;
                    o_ibus_rdt = w_rdt;
                end
                if (r_grant == GNT_DBUS) begin
                    o_dbus_ack = 1'b1;
                    o_dbus_rdt = w_rdt;
                end
                w_next = ST_GAP;
            end
            ST_GAP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serv_ram_responder.sv
module tb_serv_ram_responder;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ibus_cyc;
    logic [31:0]   ibus_adr;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic          dbus_cyc;
    logic [31:0]   dbus_adr;
    logic          dbus_we;
    logic [31:0]   dbus_dat;
    logic [3:0]    dbus_sel;
    logic [31:0]   dbus_rdt;
    logic          dbus_ack;
    logic          host_we;
    logic [AW+1:0] host_addr;
    logic [7:0]    host_data;
    logic          host_busy;
    logic          ram_en;
    logic [AW-1:0] ram_a;
    logic [3:0]    ram_we;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;

    // Bench-side preload port into the RAM model.
    logic          pl_en;
    logic [AW-1:0] pl_a;
    logic [31:0]   pl_d;
    logic [31:0]   mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    serv_ram_responder #(.AW(AW), .BASE(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ibus_cyc  (ibus_cyc),
        .i_ibus_adr  (ibus_adr),
        .o_ibus_rdt  (ibus_rdt),
        .o_ibus_ack  (ibus_ack),
        .i_dbus_cyc  (dbus_cyc),
        .i_dbus_adr  (dbus_adr),
        .i_dbus_we   (dbus_we),
        .i_dbus_dat  (dbus_dat),
        .i_dbus_sel  (dbus_sel),
        .o_dbus_rdt  (dbus_rdt),
        .o_dbus_ack  (dbus_ack),
        .i_host_we   (host_we),
        .i_host_addr (host_addr),
        .i_host_data (host_data),
        .o_host_busy (host_busy),
        .o_ram_en    (ram_en),
        .o_ram_a     (ram_a),
        .o_ram_we    (ram_we),
        .o_ram_di    (ram_di),
        .i_ram_do    (ram_do)
    );

    // Single-port synchronous RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (ram_en) begin
            ram_do <= mem[ram_a];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = AW'(a);
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    // One bus transaction from IDLE; checks ack latency and read data, returns in IDLE.
    task automatic xfer(input bit use_d, input logic [31:0] adr, input bit we,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_rdt, input string tag);
        int   n;
        bit   got;
        exp_t e;
        sb.push_back('{tag, exp_rdt});
        if (use_d) begin
            dbus_cyc = 1'b1; dbus_adr = adr; dbus_we = we; dbus_dat = dat; dbus_sel = sel;
        end else begin
            ibus_cyc = 1'b1; ibus_adr = adr;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            tick();
            n++;
            got = use_d ? dbus_ack : ibus_ack;
        end
        check({tag, "_latency"}, n, 2);
        if (got) begin
            e = sb.pop_front();
            check({e.tag, "_rdt"}, use_d ? dbus_rdt : ibus_rdt, e.rdt);
        end
        dbus_cyc = 1'b0;
        ibus_cyc = 1'b0;
        dbus_we  = 1'b0;
        tick();
        check({tag, "_gap_noack"}, {30'b0, ibus_ack, dbus_ack}, 32'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        ibus_cyc  = 1'b1;
        ibus_adr  = 32'h0000_000C;
        dbus_cyc  = 1'b0;
        dbus_adr  = 32'b0;
        dbus_we   = 1'b0;
        dbus_dat  = 32'b0;
        dbus_sel  = 4'b0;
        host_we   = 1'b0;
        host_addr = '0;
        host_data = 8'b0;
        pl_en     = 1'b0;
        pl_a      = '0;
        pl_d      = 32'b0;

        for (int i = 0; i < (1 << AW); i++) preload(i, 32'b0);
        preload(3, 32'hDEADBEEF);
        preload(2, 32'h11223344);

        // Reset held two cycles with ibus_cyc high.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_ack", {30'b0, ibus_ack, dbus_ack}, 32'b0);
            check("rst_ram_en", {31'b0, ram_en}, 32'b0);
            check("rst_busy", {31'b0, host_busy}, 32'b0);
            check("rst_ram_a", {27'b0, ram_a}, 32'b0);
        end
        rst_n = 1'b1;
        check("rel_c1_ack", {31'b0, ibus_ack}, 32'b0);
        tick();
        check("rel_c2_ack", {31'b0, ibus_ack}, 32'b0);
        check("fetch_ram_en", {31'b0, ram_en}, 32'b1);
        check("fetch_ram_a", {27'b0, ram_a}, 32'd3);
        tick();
        check("rel_c3_ack", {31'b0, ibus_ack}, 32'b1);
        check("fetch_rdt", ibus_rdt, 32'hDEADBEEF);
        ibus_cyc = 1'b0;
        tick();
        check("fetch_ack_once", {31'b0, ibus_ack}, 32'b0);
        tick();

        // Fetch through the scoreboard path.
        xfer(1'b0, 32'h0000_000C, 1'b0, 32'b0, 4'b0, 32'hDEADBEEF, "fetch2");

        // Byte write then read-back.
        xfer(1'b1, 32'h0000_0008, 1'b1, 32'h00AB_0000, 4'b0100, 32'b0, "bytewr");
        xfer(1'b1, 32'h0000_0008, 1'b0, 32'b0, 4'b0, 32'h11AB3344, "byterd");

        // Host loader, plus a strobe while busy that must be dropped.
        host_we   = 1'b1;
        host_addr = 7'h05;
        host_data = 8'h5A;
        tick();
        host_we = 1'b0;
        check("host_ram_we", {28'b0, ram_we}, 32'h2);
        check("host_ram_di", ram_di, 32'h0000_5A00);
        check("host_ram_a", {27'b0, ram_a}, 32'd1);
        check("host_busy", {31'b0, host_busy}, 32'b1);
        host_we   = 1'b1;
        host_addr = 7'h04;
        host_data = 8'h77;
        tick();
        host_we = 1'b0;
        check("host_noack", {30'b0, ibus_ack, dbus_ack}, 32'b0);
        check("host_idle_busy", {31'b0, host_busy}, 32'b0);
        check("host_idle_we", {28'b0, ram_we}, 32'b0);
        xfer(1'b1, 32'h0000_0004, 1'b0, 32'b0, 4'b0, 32'h0000_5A00, "hostrd");

        // Contention: dbus first, ibus on the following IDLE.
        sb.push_back('{"cont_dbus", 32'h11AB3344});
        sb.push_back('{"cont_ibus", 32'hDEADBEEF});
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_0008; dbus_we = 1'b0;
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_000C;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("cont_dack_c%0d", c), {31'b0, dbus_ack}, {31'b0, c == 2});
            check($sformatf("cont_iack_c%0d", c), {31'b0, ibus_ack}, {31'b0, c == 6});
            check($sformatf("cont_excl_c%0d", c), {31'b0, ibus_ack & dbus_ack}, 32'b0);
            if (dbus_ack || ibus_ack) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check(e.tag, dbus_ack ? dbus_rdt : ibus_rdt, e.rdt);
                end
            end
            if (dbus_ack) dbus_cyc = 1'b0;
            if (ibus_ack) ibus_cyc = 1'b0;
        end
        check("cont_sb_empty", sb.size(), 0);
        dbus_cyc = 1'b0;
        ibus_cyc = 1'b0;

        // Out-of-range read: no RAM enable, zero data despite stale RAM output.
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_0100; dbus_we = 1'b0;
        tick();
        check("oor_ram_en", {31'b0, ram_en}, 32'b0);
        tick();
        check("oor_ack", {31'b0, dbus_ack}, 32'b1);
        check("oor_rdt", dbus_rdt, 32'b0);
        dbus_cyc = 1'b0;
        tick();
        tick();

        // Out-of-range write must not touch the RAM.
        dbus_cyc = 1'b1; dbus_adr = 32'h0000_0108; dbus_we = 1'b1;
        dbus_dat = 32'hFFFF_FFFF; dbus_sel = 4'b1111;
        tick();
        check("oorw_ram_en", {31'b0, ram_en}, 32'b0);
        check("oorw_ram_we", {28'b0, ram_we}, 32'b0);
        tick();
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        tick();
        tick();
        xfer(1'b1, 32'h0000_0008, 1'b0, 32'b0, 4'b0, 32'h11AB3344, "oorw_intact");

        // Reset during a transaction aborts it with no ack.
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_000C;
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_ram_en", {31'b0, ram_en}, 32'b0);
        check("abort_ack", {30'b0, ibus_ack, dbus_ack}, 32'b0);
        ibus_cyc = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("abort_ack2", {30'b0, ibus_ack, dbus_ack}, 32'b0);
        tick();
        check("abort_ack3", {30'b0, ibus_ack, dbus_ack}, 32'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
